// File: rtl/speed_clkgen.sv
// Clock-path front end: divides the board clock into 2/5/10 Hz square waves and
// turns debounced presses of the speed button into a cycling 0->1->2 SPEED code.
module speed_clkgen #(
  parameter int CLK_HZ  = 50000000,
  parameter int CNT_W   = 24,
  parameter int DEB_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_speed,
  output logic       clk2hz,
  output logic       clk5hz,
  output logic       clk10hz,
  output logic [1:0] SPEED,
  output logic       press
);

  localparam int HALF2  = CLK_HZ / 4;
  localparam int HALF5  = CLK_HZ / 10;
  localparam int HALF10 = CLK_HZ / 20;
  localparam logic [CNT_W-1:0] LAST2  = CNT_W'(HALF2 - 1);
  localparam logic [CNT_W-1:0] LAST5  = CNT_W'(HALF5 - 1);
  localparam logic [CNT_W-1:0] LAST10 = CNT_W'(HALF10 - 1);

  localparam int DW = $clog2(DEB_CYC);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

  logic [CNT_W-1:0] cnt2, cnt5, cnt10;
  logic             s1, s2, lvl;
  logic [DW-1:0]    deb_cnt;
  logic             accept, rise;
  logic [1:0]       speed_nxt;

  // Each divider is free-running; phases only relate through the shared reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt2   <= '0;
      clk2hz <= 1'b0;
    end else if (cnt2 == LAST2) begin
      cnt2   <= '0;
      clk2hz <= ~clk2hz;
    end else begin
      cnt2   <= cnt2 + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt5   <= '0;
      clk5hz <= 1'b0;
    end else if (cnt5 == LAST5) begin
      cnt5   <= '0;
      clk5hz <= ~clk5hz;
    end else begin
      cnt5   <= cnt5 + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt10   <= '0;
      clk10hz <= 1'b0;
    end else if (cnt10 == LAST10) begin
      cnt10   <= '0;
      clk10hz <= ~clk10hz;
    end else begin
      cnt10   <= cnt10 + CNT_W'(1);
    end
  end

  // A level change is accepted after DEB_CYC consecutive disagreeing samples.
  always_comb begin
    accept    = (s2 != lvl) && (deb_cnt == DEB_LAST);
    rise      = accept && s2;
    speed_nxt = 2'd0;
    case (SPEED)
      2'd0:    speed_nxt = 2'd1;
      2'd1:    speed_nxt = 2'd2;
      default: speed_nxt = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      lvl     <= 1'b0;
      deb_cnt <= '0;
      press   <= 1'b0;
      SPEED   <= 2'd0;
    end else begin
      s1    <= btn_speed;
      s2    <= s1;
      press <= rise;
      if (s2 == lvl) begin
        deb_cnt <= '0;
      end else if (accept) begin
        lvl     <= s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
      if (rise) SPEED <= speed_nxt;
    end
  end

endmodule

// File: tb/tb_speed_clkgen.sv
// Bench for speed_clkgen: a per-edge reference model pushes expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_speed_clkgen;

  localparam int CLK_HZ = 100;
  localparam int DEB    = 4;
  localparam int HALF2  = CLK_HZ / 4;
  localparam int HALF5  = CLK_HZ / 10;
  localparam int HALF10 = CLK_HZ / 20;
  localparam int HLEN   = DEB + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_speed = 1'b0;
  logic       clk2hz, clk5hz, clk10hz, press;
  logic [1:0] SPEED;

  int n_checks = 0;
  int n_fail   = 0;
  int hi2 = 0, hi5 = 0, hi10 = 0, press_cnt = 0;

  logic [5:0] exp_q[$];

  // model state
  int   m_n = 0;
  int   m_speed = 0;
  bit   m_lvl = 0;
  bit   m_press = 0;
  bit   hist[$];

  speed_clkgen #(.CLK_HZ(CLK_HZ), .CNT_W(8), .DEB_CYC(DEB)) dut (
    .clk(clk), .rst(rst), .btn_speed(btn_speed),
    .clk2hz(clk2hz), .clk5hz(clk5hz), .clk10hz(clk10hz),
    .SPEED(SPEED), .press(press)
  );

  always #5 clk = ~clk;

  // Reference model: square waves from the edge count since reset release;
  // debounced level flips once the last DEB synchronised samples all disagree.
  always @(posedge clk or posedge rst) begin
    bit all_diff;
    bit e2, e5, e10;
    if (rst) begin
      m_n = 0;
      m_lvl = 0;
      m_speed = 0;
      m_press = 0;
      hist.delete();
      for (int i = 0; i < HLEN; i++) hist.push_back(1'b0);
      exp_q.delete();
    end else begin
      m_n++;
      hist.push_back(btn_speed);
      void'(hist.pop_front());
      all_diff = 1'b1;
      for (int i = 0; i < DEB; i++) if (hist[i] == m_lvl) all_diff = 1'b0;
      m_press = 0;
      if (all_diff) begin
        m_lvl = !m_lvl;
        if (m_lvl) begin
          m_press = 1;
          m_speed = (m_speed >= 2) ? 0 : m_speed + 1;
        end
      end
    end
    e2  = ((m_n / HALF2) % 2) == 1;
    e5  = ((m_n / HALF5) % 2) == 1;
    e10 = ((m_n / HALF10) % 2) == 1;
    exp_q.push_back({e2, e5, e10, 2'(m_speed), m_press});
  end

  // Monitor
  always @(negedge clk) begin
    logic [5:0] act, exp_v;
    act = {clk2hz, clk5hz, clk10hz, SPEED, press};
    hi2  += int'(clk2hz);
    hi5  += int'(clk5hz);
    hi10 += int'(clk10hz);
    press_cnt += int'(press);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL outputs t=%0t no expected entry, got=%b", $time, act);
    end else begin
      exp_v = exp_q.pop_front();
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL outputs t=%0t {c2,c5,c10,SPEED,press} got=%b exp=%b", $time, act, exp_v);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp_v);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    hi2 = 0; hi5 = 0; hi10 = 0;
  endtask

  task automatic press_release(input int hold);
    btn_speed = 1'b1;
    step(hold);
    btn_speed = 1'b0;
    step(hold);
  endtask

  initial begin
    int p0;
    step(3);
    rst = 1'b0;
    hi2 = 0; hi5 = 0; hi10 = 0;

    // divider timing and duty over 200 cycles
    step(200);
    check("duty_clk10hz", hi10, 100);
    check("duty_clk5hz", hi5, 100);
    check("duty_clk2hz", hi2, 100);

    // clean press held 20 cycles
    p0 = press_cnt;
    btn_speed = 1'b1;
    step(20);
    check("clean_speed", SPEED, 1);
    check("clean_press_cnt", press_cnt - p0, 1);
    btn_speed = 1'b0;
    step(10);

    // bounce: 3 high / 1 low for 40 cycles
    p0 = press_cnt;
    for (int i = 0; i < 10; i++) begin
      btn_speed = 1'b1; step(3);
      btn_speed = 1'b0; step(1);
    end
    step(10);
    check("bounce_speed", SPEED, 1);
    check("bounce_press_cnt", press_cnt - p0, 0);

    // wrap-around from 0: 1,2,0,1
    do_reset();
    p0 = press_cnt;
    for (int i = 0; i < 4; i++) press_release(10);
    check("wrap_speed", SPEED, 1);
    check("wrap_press_cnt", press_cnt - p0, 4);

    // release is not a press
    p0 = press_cnt;
    press_release(10);
    check("release_speed", SPEED, 2);
    check("release_press_cnt", press_cnt - p0, 1);

    // mid-operation reset with SPEED=2, clk5hz=1, debounce counting
    for (int i = 0; i < 40; i++) begin
      if ((((m_n + 3) / HALF5) % 2) == 1) break;
      step(1);
    end
    btn_speed = 1'b1;
    step(3);
    check("pre_reset_clk5hz", clk5hz, 1);
    check("pre_reset_speed", SPEED, 2);
    rst = 1'b1;
    #2;
    check("async_reset_outputs", {clk2hz, clk5hz, clk10hz, SPEED, press}, 0);
    btn_speed = 1'b0;
    step(1);
    rst = 1'b0;
    hi2 = 0; hi5 = 0; hi10 = 0;
    step(200);
    check("rerun_duty_clk10hz", hi10, 100);
    check("rerun_duty_clk5hz", hi5, 100);
    check("rerun_duty_clk2hz", hi2, 100);
    check("rerun_speed", SPEED, 0);

    // randomized button activity with occasional resets
    for (int i = 0; i < 250; i++) begin
      btn_speed = 1'($urandom_range(0, 1));
      step($urandom_range(1, 8));
      if ($urandom_range(0, 40) == 0) do_reset();
    end
    btn_speed = 1'b0;
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/speed_clkgen.md
Name: speed_clkgen

Overview:
- Upstream stage of the speed-selected blink/scroll clock path on the Spartan-3E LCD kit.
- Divides the 50 MHz board clock into free-running 2 Hz, 5 Hz and 10 Hz square waves.
- Debounces the speed push-button and cycles a 2-bit SPEED code 0->1->2->0 on each press.
- Outputs feed the downstream clock-select stage directly: clk2hz, clk5hz, clk10hz and SPEED.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz; must be divisible by 20; sims use 100.
- CNT_W, 24, width of each divider counter; must hold CLK_HZ/4 - 1.
- DEB_CYC, 1000000, consecutive stable cycles needed to accept a button level change (20 ms at 50 MHz); must be >= 2.

Ports:
- clk  input  1  system clock, CLK_HZ.
- rst  input  1  asynchronous, active-high reset.
- btn_speed  input  1  raw, asynchronous, bouncy push-button; high = pressed.
- clk2hz  output  1  2 Hz square wave, 50% duty, registered.
- clk5hz  output  1  5 Hz square wave, 50% duty, registered.
- clk10hz  output  1  10 Hz square wave, 50% duty, registered.
- SPEED  output  2  speed select code; only values 0, 1, 2 are legal.
- press  output  1  one-cycle pulse on each accepted press.

Behaviour:
- Reset (async, rst=1):
  - clk2hz = clk5hz = clk10hz = 0; SPEED = 0; press = 0.
  - All counters = 0; sync flops = 0; debounced level = 0.
  - Asserting rst mid-operation clears everything immediately; there is no partial state after release.
- Dividers:
  - HALF2 = CLK_HZ/4, HALF5 = CLK_HZ/10, HALF10 = CLK_HZ/20.
  - Each divider has its own counter, counting 0..HALFx-1.
  - On the edge where the counter equals HALFx-1, the counter returns to 0 and the output toggles; otherwise the counter increments.
  - The first rising edge of each output occurs HALFx clk edges after reset release. Period = 2*HALFx cycles.
  - The three dividers are independent, with no phase alignment beyond the common reset.
- Synchronizer: btn_speed passes through two flops (s1, s2) before any use.
- Debounce:
  - deb_cnt (width sized for DEB_CYC) plus debounced level lvl.
  - If s2 == lvl: deb_cnt <= 0.
  - Else, if deb_cnt == DEB_CYC-1: lvl <= s2 and deb_cnt <= 0.
  - Else: deb_cnt increments.
  - Any glitch back to the old level before acceptance restarts the count from 0.
- SPEED update:
  - On the same edge that lvl goes 0->1, SPEED advances 0->1, 1->2, 2->0 and press = 1 for that single cycle.
  - A release (lvl 1->0) does not change SPEED.
  - SPEED never takes the value 3. If it is ever found at 3 (e.g. SEU), the next press loads 0.
- Latency: if btn_speed is first sampled high at edge k and stays high, SPEED changes at edge k+1+DEB_CYC.
- Holding the button produces exactly one advance; the next advance requires an accepted release followed by an accepted press.
- Simultaneous events: a divider toggle and a SPEED change on the same edge are independent and both take effect.
- No combinational paths from any input to any output.

Test Plan:
- Divider timing (CLK_HZ=100, rst released at edge 0) -> clk10hz rises at edge 5, falls at 10, rises at 15. clk5hz rises at edge 10, period 20. clk2hz rises at edge 25, period 50. Each output is high exactly 50% of cycles over 200 cycles.
- Clean press (DEB_CYC=4, btn_speed high from edge k, held 20 cycles) -> SPEED 0->1 at edge k+5, press high for exactly one cycle, no further change while held.
- Bounce rejection (DEB_CYC=4, btn_speed toggling high 3 cycles / low 1 cycle repeatedly for 40 cycles, then low) -> SPEED stays 0, press never asserts.
- Wrap-around: four clean press/release pairs (each level held 10 cycles) -> SPEED sequence 0,1,2,0,1, with one press pulse per press.
- Mid-operation reset: assert rst while SPEED=2, clk5hz=1 and deb_cnt nonzero -> all outputs 0 in the same cycle. After release, the divider timing from the first scenario repeats exactly and SPEED=0.
- Release is not a press: hold the button until accepted, then release and hold low for 10 cycles -> SPEED changes once (on press only), press pulses once.
